rcvr_arb: RTL and testbench
===========================

RCVR_ARB -- requirements
Module: rcvr_arb

Interface
REQ-001 Parameter NCH, default 4: number of receiver channels serviced; legal values 2, 4 or 8. CW = log2(NCH).
REQ-002 clock  input  1  sole clock; all state changes on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 rx_ready  input  NCH  per-channel "byte available" flag from the receiver.
REQ-005 rx_overrun  input  NCH  per-channel overrun flag from the receiver.
REQ-006 rx_data  input  8*NCH  per-channel received byte; channel i occupies bits [8i+7:8i].
REQ-007 rx_reading  output  NCH  one-hot read strobe to the granted receiver.
REQ-008 chan_en  input  NCH  per-channel enable mask; 0 = never grant that channel.
REQ-009 out_valid  output  1  captured byte presented downstream.
REQ-010 out_ack  input  1  downstream accepts the presented byte.
REQ-011 out_data  output  8  captured byte.
REQ-012 out_chan  output  CW  index of the channel that sourced out_data.
REQ-013 out_ovr  output  1  rx_overrun of the sourcing channel, sampled at grant.
REQ-014 ovr_clr  input  1  synchronous clear of ovr_cnt.
REQ-015 ovr_cnt  output  8  saturating count of bytes captured with out_ovr=1.

Function
REQ-016 FSM states: IDLE, PRESENT; reset state IDLE.
REQ-017 Eligible set = rx_ready & chan_en.
REQ-018 IDLE with eligible set nonzero: grant the first eligible channel searching upward from ptr, wrapping NCH-1 -> 0.
REQ-019 On the grant edge: load out_data, out_chan, out_ovr from the granted channel; set out_valid=1; assert rx_reading[granted]=1; enter PRESENT.
REQ-020 rx_reading is registered, high exactly one cycle per grant, never more than one bit high.
REQ-021 IDLE with eligible set zero: remain IDLE; out_valid=0; rx_reading=0.
REQ-022 PRESENT: out_data, out_chan and out_ovr hold stable; out_valid=1; rx_ready and rx_data changes are ignored.
REQ-023 PRESENT with out_ack=1: next edge clears out_valid, sets ptr = out_chan+1 mod NCH, and enters IDLE. The earliest next grant is the following edge (max 1 byte per 2 cycles).
REQ-024 out_ack while out_valid=0 is ignored.
REQ-025 ptr resets to 0 and changes only on accept; the last-served channel becomes lowest priority (round robin, no starvation among enabled ready channels).
REQ-026 ovr_cnt increments by 1 on each grant edge where the granted channel's rx_overrun=1, and saturates at 255 with no wrap.
REQ-027 ovr_clr=1 sets ovr_cnt to 0 at the next edge; clear wins over a simultaneous increment.
REQ-028 A chan_en bit dropped during PRESENT does not affect the byte being presented; it affects only later grants.

Reset
REQ-029 While reset=0, asynchronously: state=IDLE, ptr=0, out_valid=0, rx_reading=0, out_data=0, out_chan=0, out_ovr=0, ovr_cnt=0.
REQ-030 Reset asserted mid-PRESENT discards the presented byte; no rx_reading is issued after release until a new grant.
REQ-031 The first grant is possible on the first rising edge after reset deasserts.

Verification
REQ-032 NCH=4; channel 2 ready with data 8'h3C, out_ack held 1 -> rx_reading=4'b0100 for one cycle; out_valid=1 with out_data=8'h3C, out_chan=2, out_ovr=0; accepted the next edge; then IDLE.
REQ-033 All 4 channels held ready, chan_en=4'hF, out_ack=1 -> grant order 0,1,2,3,0 (wrap); grants are 2 cycles apart.
REQ-034 Channel 1 ready, out_ack=0 for 5 cycles -> out_valid and out_data stable for all 5 cycles; rx_reading high only in the grant cycle; ack on cycle 6 -> IDLE.
REQ-035 chan_en=4'b1011, channels 2 and 3 ready, ptr=2 -> channel 3 granted; channel 2 never granted.
REQ-036 300 grants with rx_overrun=1 -> ovr_cnt stops at 8'hFF; ovr_clr coinciding with an overrun grant -> ovr_cnt=0.
REQ-037 reset=0 asserted asynchronously mid-PRESENT -> all outputs 0 immediately; after release with no ready channel -> IDLE, out_valid=0.

Source files
------------

// File: rtl/rcvr_arb.sv
// Round-robin arbiter that collects bytes from NCH receiver channels and
// presents them one at a time downstream, with a saturating overrun counter.
module rcvr_arb #(
  parameter int NCH = 4,
  localparam int CW = $clog2(NCH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [NCH-1:0]   rx_ready,
  input  logic [NCH-1:0]   rx_overrun,
  input  logic [8*NCH-1:0] rx_data,
  output logic [NCH-1:0]   rx_reading,
  input  logic [NCH-1:0]   chan_en,
  output logic             out_valid,
  input  logic             out_ack,
  output logic [7:0]       out_data,
  output logic [CW-1:0]    out_chan,
  output logic             out_ovr,
  input  logic             ovr_clr,
  output logic [7:0]       ovr_cnt
);

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_nextState;
  logic [CW-1:0]    r_ptr;
  logic [7:0]       r_data;
  logic [CW-1:0]    r_chan;
  logic             r_ovr;
  logic             r_valid;
  logic [NCH-1:0]   r_reading;
  logic [7:0]       r_ovrCnt;

  logic [NCH-1:0]   w_elig;
  logic             w_found;
  logic [CW-1:0]    w_grantIdx;
  logic             w_grant;
  logic             w_accept;

  assign w_elig = rx_ready & chan_en;

  // First eligible channel at or above the pointer, wrapping around.
  always_comb begin : search
    logic [CW-1:0] idx;
    w_found    = 1'b0;
    w_grantIdx = '0;
    for (int k = 0; k < NCH; k++) begin
      idx = r_ptr + CW'(k);
      if (!w_found && w_elig[idx]) begin
        w_found    = 1'b1;
        w_grantIdx = idx;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    w_grant     = 1'b0;
    w_accept    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_found) begin
          w_grant     = 1'b1;
          w_nextState = PRESENT;
        end
      end
      PRESENT: begin
        if (out_ack) begin
          w_accept    = 1'b1;
          w_nextState = IDLE;
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  // Capture on grant, hold through PRESENT; pointer moves only on accept.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_ptr     <= '0;
      r_data    <= '0;
      r_chan    <= '0;
      r_ovr     <= 1'b0;
      r_valid   <= 1'b0;
      r_reading <= '0;
    end else begin
      r_reading <= '0;
      if (w_grant) begin
        r_data    <= rx_data[8*w_grantIdx +: 8];
        r_chan    <= w_grantIdx;
        r_ovr     <= rx_overrun[w_grantIdx];
        r_valid   <= 1'b1;
        r_reading <= NCH'(1) << w_grantIdx;
      end else if (w_accept) begin
        r_valid <= 1'b0;
        r_ptr   <= r_chan + CW'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_ovrCnt <= '0;
    end else if (ovr_clr) begin
      r_ovrCnt <= '0;
    end else if (w_grant && rx_overrun[w_grantIdx] && (r_ovrCnt != 8'hFF)) begin
      r_ovrCnt <= r_ovrCnt + 8'd1;
    end
  end

  assign rx_reading = r_reading;
  assign out_valid  = r_valid;
  assign out_data   = r_data;
  assign out_chan   = r_chan;
  assign out_ovr    = r_ovr;
  assign ovr_cnt    = r_ovrCnt;

endmodule

// File: tb/tb_rcvr_arb.sv
// Self-checking bench for rcvr_arb: directed scenarios plus random traffic
// compared every cycle against a behavioural model of the arbitration rules.
module tb_rcvr_arb;
  localparam int NCH = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  rx_ready = '0;
  logic [3:0]  rx_overrun = '0;
  logic [31:0] rx_data = '0;
  logic [3:0]  chan_en = '0;
  logic        out_ack = 1'b0;
  logic        ovr_clr = 1'b0;
  logic [3:0]  rx_reading;
  logic        out_valid;
  logic [7:0]  out_data;
  logic [1:0]  out_chan;
  logic        out_ovr;
  logic [7:0]  ovr_cnt;

  int nAsserts = 0;
  int nFails = 0;

  int mPtr, mData, mChan, mOvr, mCnt, mReading, mValid;

  rcvr_arb #(.NCH(NCH)) dut (
    .clock(clock), .reset(reset),
    .rx_ready(rx_ready), .rx_overrun(rx_overrun), .rx_data(rx_data),
    .rx_reading(rx_reading), .chan_en(chan_en),
    .out_valid(out_valid), .out_ack(out_ack), .out_data(out_data),
    .out_chan(out_chan), .out_ovr(out_ovr),
    .ovr_clr(ovr_clr), .ovr_cnt(ovr_cnt)
  );

  always #5 clock = ~clock;

  task automatic check1(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nAsserts++;
    assert (got === exp) else begin
      nFails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic modelReset();
    mPtr = 0; mData = 0; mChan = 0; mOvr = 0; mCnt = 0; mReading = 0; mValid = 0;
  endtask

  // One clock edge of the arbitration rules, using the inputs held across it.
  task automatic modelEdge();
    int inc;
    bit found;
    inc = 0;
    mReading = 0;
    if (mValid != 0) begin
      if (out_ack) begin
        mValid = 0;
        mPtr = (mChan + 1) % NCH;
      end
    end else begin
      found = 0;
      for (int off = 0; off < NCH; off++) begin
        int ch;
        ch = (mPtr + off) % NCH;
        if (!found && rx_ready[ch] && chan_en[ch]) begin
          found = 1;
          mData = int'(rx_data[8*ch +: 8]);
          mChan = ch;
          mOvr = int'(rx_overrun[ch]);
          mValid = 1;
          mReading = 1 << ch;
          inc = int'(rx_overrun[ch]);
        end
      end
    end
    if (ovr_clr) mCnt = 0;
    else if (inc != 0 && mCnt < 255) mCnt = mCnt + 1;
  endtask

  task automatic checkOutput(input string tag);
    check1({tag, ".rx_reading"}, 32'(rx_reading), 32'(mReading));
    check1({tag, ".out_valid"}, 32'(out_valid), 32'(mValid));
    check1({tag, ".out_data"}, 32'(out_data), 32'(mData));
    check1({tag, ".out_chan"}, 32'(out_chan), 32'(mChan));
    check1({tag, ".out_ovr"}, 32'(out_ovr), 32'(mOvr));
    check1({tag, ".ovr_cnt"}, 32'(ovr_cnt), 32'(mCnt));
  endtask

  task automatic applyStimulus(input string tag, input logic [3:0] rdy, input logic [3:0] ovr,
                               input logic [31:0] dat, input logic [3:0] en,
                               input logic ack, input logic clr);
    @(negedge clock);
    rx_ready = rdy; rx_overrun = ovr; rx_data = dat; chan_en = en;
    out_ack = ack; ovr_clr = clr;
    @(posedge clock);
    modelEdge();
    #1;
    checkOutput(tag);
  endtask

  task automatic doReset();
    @(negedge clock);
    reset = 1'b0;
    rx_ready = '0; rx_overrun = '0; rx_data = '0; chan_en = '0;
    out_ack = 1'b0; ovr_clr = 1'b0;
    #1;
    modelReset();
    checkOutput("reset");
    @(negedge clock);
    reset = 1'b1;
  endtask

  initial begin
    modelReset();
    #2;
    checkOutput("powerOnReset");
    doReset();

    // Single channel 2 byte with ack held high.
    applyStimulus("ch2Grant", 4'b0100, 4'b0000, 32'h003C_0000, 4'hF, 1'b1, 1'b0);
    check1("ch2Grant.strobe", 32'(rx_reading), 32'h4);
    check1("ch2Grant.data", 32'(out_data), 32'h3C);
    check1("ch2Grant.chan", 32'(out_chan), 32'd2);
    applyStimulus("ch2Accept", 4'b0000, 4'b0000, 32'h0, 4'hF, 1'b1, 1'b0);
    check1("ch2Accept.valid", 32'(out_valid), 32'd0);
    applyStimulus("ch2Idle", 4'b0000, 4'b0000, 32'h0, 4'hF, 1'b1, 1'b0);

    // All channels ready: grant order 0,1,2,3,0 two cycles apart.
    doReset();
    for (int i = 0; i < 10; i++) begin
      applyStimulus("rrOrder", 4'hF, 4'h0, 32'h4433_2211, 4'hF, 1'b1, 1'b0);
      if (i % 2 == 0) begin
        check1("rrOrder.chan", 32'(out_chan), 32'((i / 2) % 4));
        check1("rrOrder.strobe", 32'(rx_reading), 32'(1 << ((i / 2) % 4)));
      end else begin
        check1("rrOrder.gap", 32'(rx_reading), 32'd0);
      end
    end

    // Channel 1 held without ack: byte must stay put while inputs churn.
    doReset();
    applyStimulus("holdGrant", 4'b0010, 4'b0000, 32'h0000_A500, 4'hF, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus("holdStable", 4'($urandom), 4'($urandom), $urandom, 4'hF, 1'b0, 1'b0);
      check1("holdStable.data", 32'(out_data), 32'hA5);
      check1("holdStable.strobe", 32'(rx_reading), 32'd0);
    end
    applyStimulus("holdAccept", 4'b0000, 4'b0000, 32'h0, 4'hF, 1'b1, 1'b0);
    check1("holdAccept.valid", 32'(out_valid), 32'd0);

    // Pointer now at 2 with channel 2 masked: channel 3 wins, 2 never does.
    applyStimulus("maskGrant", 4'b1100, 4'b0000, 32'h7700_0000, 4'b1011, 1'b1, 1'b0);
    check1("maskGrant.chan", 32'(out_chan), 32'd3);
    for (int i = 0; i < 6; i++) begin
      applyStimulus("maskNever", 4'b0100, 4'b0000, 32'h0011_0000, 4'b1011, 1'b1, 1'b0);
      check1("maskNever.strobe", 32'(rx_reading[2]), 32'd0);
    end

    // Overrun saturation, then clear colliding with an overrun grant.
    doReset();
    for (int i = 0; i < 600; i++) begin
      applyStimulus("ovrSat", 4'hF, 4'hF, $urandom, 4'hF, 1'b1, 1'b0);
    end
    check1("ovrSat.cnt", 32'(ovr_cnt), 32'hFF);
    applyStimulus("ovrClr", 4'hF, 4'hF, $urandom, 4'hF, 1'b1, 1'b1);
    check1("ovrClr.cnt", 32'(ovr_cnt), 32'd0);
    check1("ovrClr.granted", 32'(out_valid), 32'd1);

    // Asynchronous reset in the middle of a presented byte.
    applyStimulus("preRst", 4'h0, 4'h0, 32'h0, 4'hF, 1'b1, 1'b0);
    applyStimulus("preRstGrant", 4'b0001, 4'b0001, 32'h0000_00EE, 4'hF, 1'b0, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    modelReset();
    checkOutput("asyncRst");
    rx_ready = '0;
    @(negedge clock);
    reset = 1'b1;
    applyStimulus("postRstIdle", 4'h0, 4'h0, 32'h0, 4'hF, 1'b1, 1'b0);
    check1("postRstIdle.valid", 32'(out_valid), 32'd0);

    // Random traffic against the model.
    for (int i = 0; i < 500; i++) begin
      applyStimulus("random", 4'($urandom), 4'($urandom), $urandom, 4'($urandom),
                    1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 15) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
    $finish;
  end

endmodule
